// File: rtl/arm_mem_pkg.sv
// Shared constants for the unified-memory arbiter: FSM state encoding,
// grant encoding and the legal read-latency range.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CPU = 2'd1,
    RD_DMA = 2'd2
  } state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  function automatic bit lat_ok(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin picker. req[0] is the CPU, req[1] is the DMA port.
// On a tie the requester that did not win last time is chosen; with no
// request the output is CPU and must be ignored by the caller.
module arb_rr2
  import arm_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  // Pure combinational pick
  always_comb begin
    grant = GNT_CPU;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = GNT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one synchronous memory between
// the multicycle CPU (stall interface) and a DMA/loader port (req/ack).
//
// Handshakes:
//   CPU: cpu_req is held by the CPU while cpu_stall=1; the cycle with
//        cpu_req=1 and cpu_stall=0 is the completion cycle (read data valid).
//   DMA: dma_req and its qualifiers are held until dma_ack; dma_ack is a
//        single-cycle pulse and dma_rdata is valid only in that cycle.
//   MEM: mem_en is a one-cycle strobe per access; read data arrives LAT
//        cycles after the strobe edge while address/we/wdata are held.
module mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  if (!lat_ok(LAT)) begin : g_lat_bad
    $error("mem_arbiter: LAT out of range 1..15");
  end

  localparam int              CNT_W    = $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(LAT);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              last_grant;
  logic              hold_we;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;

  logic              grant;
  logic              issue;
  logic              win_dma;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              cpu_rd_done;
  logic              dma_rd_done;
  logic              cpu_done;
  logic              dma_done;

  arb_rr2 u_arb (
    .req        ({dma_req, cpu_req}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Winner selection and completion decode; reset blocks any issue so the
  // memory sees no strobe while reset is held
  always_comb begin
    issue       = (state == IDLE) && !reset && (cpu_req || dma_req);
    win_dma     = (grant == GNT_DMA);
    win_we      = win_dma ? dma_we    : cpu_we;
    win_addr    = win_dma ? dma_addr  : cpu_addr;
    win_wdata   = win_dma ? dma_wdata : cpu_wdata;
    cpu_rd_done = (state == RD_CPU) && (cnt == CNT_DONE);
    dma_rd_done = (state == RD_DMA) && (cnt == CNT_DONE);
    cpu_done    = (issue && !win_dma && cpu_we) || cpu_rd_done;
    dma_done    = (issue &&  win_dma && dma_we) || dma_rd_done;
  end

  // Memory-side muxing and requester-side responses
  always_comb begin
    mem_en = issue;
    if (issue) begin
      mem_we    = win_we;
      mem_addr  = win_addr;
      mem_wdata = win_wdata;
    end else begin
      mem_we    = (state != IDLE) && hold_we;
      mem_addr  = hold_addr;
      mem_wdata = hold_wdata;
    end
    cpu_rdata = cpu_rd_done ? mem_rdata : '0;
    dma_rdata = dma_rd_done ? mem_rdata : '0;
    cpu_stall = cpu_req && !cpu_done;
    dma_ack   = dma_done;
    dbg_state = state;
  end

  // FSM, latency counter, grant history and hold registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= GNT_DMA;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            last_grant <= grant;
            hold_we    <= win_we;
            hold_addr  <= win_addr;
            hold_wdata <= win_wdata;
            if (!win_we) begin
              state <= win_dma ? RD_DMA : RD_CPU;
              cnt   <= CNT_W'(1);
            end
          end
        end
        RD_CPU, RD_DMA: begin
          if (cnt == CNT_DONE) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (LAT=1 and LAT=3), each with its own
// synchronous memory model, checked every cycle against a transaction-level
// reference model, plus a hand-derived vector table and directed sequences.
`timescale 1ns/1ps
module tb_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 4) return 32'hE3A00001;
    return {idx[7:0] ^ 8'hA5, 8'h3C, idx[7:0], ~idx[7:0]};
  endfunction

  // ---------------- stimulus arrays (per instance) ----------------
  logic        cpu_req_i [2];
  logic        cpu_we_i  [2];
  logic [31:0] cpu_addr_i[2];
  logic [31:0] cpu_wd_i  [2];
  logic        dma_req_i [2];
  logic        dma_we_i  [2];
  logic [31:0] dma_addr_i[2];
  logic [31:0] dma_wd_i  [2];

  // ---------------- DUTs and memory models ----------------
  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int LK = (k == 0) ? 1 : 3;
    logic        mem_en, mem_we, cpu_stall, dma_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, cpu_rdata, dma_rdata;
    logic [1:0]  dbg_state;
    logic [31:0] mem  [256];
    logic [31:0] pipe [LK];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LK)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req_i[k]), .cpu_we(cpu_we_i[k]), .cpu_addr(cpu_addr_i[k]),
      .cpu_wdata(cpu_wd_i[k]), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req_i[k]), .dma_we(dma_we_i[k]), .dma_addr(dma_addr_i[k]),
      .dma_wdata(dma_wd_i[k]), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    end

    always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[9:2]] : 32'h0;
      for (int i = 1; i < LK; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LK-1];
  end

  // ---------------- sampled outputs ----------------
  logic        s_en[2], s_we[2], s_stall[2], s_ack[2];
  logic [31:0] s_addr[2], s_wd[2], s_crd[2], s_drd[2];
  logic [1:0]  s_st[2];

  task automatic snap();
    s_en[0] = g_dut[0].mem_en;    s_we[0] = g_dut[0].mem_we;
    s_addr[0] = g_dut[0].mem_addr; s_wd[0] = g_dut[0].mem_wdata;
    s_stall[0] = g_dut[0].cpu_stall; s_ack[0] = g_dut[0].dma_ack;
    s_crd[0] = g_dut[0].cpu_rdata; s_drd[0] = g_dut[0].dma_rdata;
    s_st[0] = g_dut[0].dbg_state;
    s_en[1] = g_dut[1].mem_en;    s_we[1] = g_dut[1].mem_we;
    s_addr[1] = g_dut[1].mem_addr; s_wd[1] = g_dut[1].mem_wdata;
    s_stall[1] = g_dut[1].cpu_stall; s_ack[1] = g_dut[1].dma_ack;
    s_crd[1] = g_dut[1].cpu_rdata; s_drd[1] = g_dut[1].dma_rdata;
    s_st[1] = g_dut[1].dbg_state;
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // An access is either a one-cycle write or a read occupying LAT further
  // cycles; "busy" counts the remaining wait cycles, the last one completes.
  int          busy   [2];
  int          owner  [2];   // 0 = CPU, 1 = DMA
  int          last   [2];   // requester served most recently
  logic [31:0] own_addr[2];
  logic [31:0] shadow [2][256];
  logic        m_cpu_done[2], m_dma_done[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy[k] = 0; owner[k] = 0; last[k] = 1; own_addr[k] = 0;
      m_cpu_done[k] = 0; m_dma_done[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int lk, w;
    logic cd, dd, e_en, e_we, chk_a, chk_rd;
    logic [31:0] e_addr, e_wd, rd;
    lk = (k == 0) ? 1 : 3;
    cd = 0; dd = 0; e_en = 0; e_we = 0; chk_a = 0; chk_rd = 1;
    e_addr = 0; e_wd = 0; rd = 0; w = 0;
    if (reset) begin
      busy[k] = 0; last[k] = 1;
      m_cpu_done[k] = 0; m_dma_done[k] = 0;
      chk($sformatf("m%0d_rst_en", k), s_en[k], 0);
      chk($sformatf("m%0d_rst_ack", k), s_ack[k], 0);
      chk($sformatf("m%0d_rst_stall", k), s_stall[k], cpu_req_i[k]);
      return;
    end
    if (busy[k] > 0) begin
      chk_a = 1; e_addr = own_addr[k];
      if (busy[k] == 1) begin
        rd = shadow[k][own_addr[k][9:2]];
        if (owner[k] == 0) cd = 1; else dd = 1;
      end
      busy[k]--;
    end else if (cpu_req_i[k] || dma_req_i[k]) begin
      if (cpu_req_i[k] && dma_req_i[k]) w = (last[k] == 1) ? 0 : 1;
      else w = dma_req_i[k] ? 1 : 0;
      last[k] = w; e_en = 1; chk_a = 1;
      e_addr = w ? dma_addr_i[k] : cpu_addr_i[k];
      e_we   = w ? dma_we_i[k]   : cpu_we_i[k];
      e_wd   = w ? dma_wd_i[k]   : cpu_wd_i[k];
      if (e_we) begin
        shadow[k][e_addr[9:2]] = e_wd;
        chk_rd = 0;
        if (w == 0) cd = 1; else dd = 1;
      end else begin
        busy[k] = lk; owner[k] = w; own_addr[k] = e_addr;
      end
    end
    chk($sformatf("m%0d_en", k), s_en[k], e_en);
    chk($sformatf("m%0d_we", k), s_we[k], e_we);
    if (chk_a) chk($sformatf("m%0d_addr", k), s_addr[k], e_addr);
    if (e_we)  chk($sformatf("m%0d_wdata", k), s_wd[k], e_wd);
    chk($sformatf("m%0d_stall", k), s_stall[k], cpu_req_i[k] && !cd);
    chk($sformatf("m%0d_ack", k), s_ack[k], dd);
    if (chk_rd) begin
      chk($sformatf("m%0d_crd", k), s_crd[k], cd ? rd : 32'h0);
      chk($sformatf("m%0d_drd", k), s_drd[k], dd ? rd : 32'h0);
    end
    m_cpu_done[k] = cd; m_dma_done[k] = dd;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    snap();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic cr, input logic cw, input logic [31:0] ca,
                         input logic [31:0] cd, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd);
    for (int k = 0; k < 2; k++) begin
      cpu_req_i[k] = cr; cpu_we_i[k] = cw; cpu_addr_i[k] = ca; cpu_wd_i[k] = cd;
      dma_req_i[k] = dr; dma_we_i[k] = dw; dma_addr_i[k] = da; dma_wd_i[k] = dd;
    end
  endtask

  task automatic new_cpu(input int k);
    int a;
    a = $urandom_range(63, 0);
    cpu_req_i[k] = 1; cpu_we_i[k] = ($urandom_range(99, 0) < 30);
    cpu_addr_i[k] = 32'(a) << 2; cpu_wd_i[k] = $urandom;
  endtask

  task automatic new_dma(input int k);
    int a;
    a = $urandom_range(63, 0);
    dma_req_i[k] = 1; dma_we_i[k] = ($urandom_range(99, 0) < 30);
    dma_addr_i[k] = 32'(a) << 2; dma_wd_i[k] = $urandom;
  endtask

  // ---------------- vector table (LAT=1 instance expectations) ----------------
  typedef struct {
    logic cr, cw; logic [31:0] ca, cd;
    logic dr, dw; logic [31:0] da, dd;
    logic e_en, e_we, chk_a; logic [31:0] e_addr;
    logic e_stall, chk_rd; logic [31:0] e_crd;
    logic e_ack; logic [31:0] e_drd;
  } vec_t;

  vec_t tbl[17];

  // ---------------- test sequence ----------------
  initial begin
    logic        e_en1 [8];
    logic        e_ack1[8];
    logic        e_st1 [8];
    int          first_k1, acks_k1;
    logic        seen_k1;

    reset = 1'b1;
    set_all(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) shadow[k][i] = init_word(i);

    // Reset state
    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d_state", k), s_st[k], 2'd0);
      chk($sformatf("rst%0d_we", k), s_we[k], 0);
      chk($sformatf("rst%0d_stall", k), s_stall[k], 0);
    end
    tick();
    reset = 1'b0;

    // Table: hand-derived expectations for the LAT=1 instance
    tbl[0]  = '{0,0,32'h00,0,           0,0,32'h00,0,           0,0,0,32'h00, 0,1,0,                0,0};
    tbl[1]  = '{1,0,32'h10,0,           0,0,32'h00,0,           1,0,1,32'h10, 1,1,0,                0,0};
    tbl[2]  = '{1,0,32'h10,0,           0,0,32'h00,0,           0,0,1,32'h10, 0,1,32'hE3A00001,     0,0};
    tbl[3]  = '{1,1,32'h20,32'hDEADBEEF,0,0,32'h00,0,           1,1,1,32'h20, 0,0,0,                0,0};
    tbl[4]  = '{0,0,32'h00,0,           0,0,32'h00,0,           0,0,0,32'h00, 0,1,0,                0,0};
    tbl[5]  = '{1,0,32'h20,0,           0,0,32'h00,0,           1,0,1,32'h20, 1,1,0,                0,0};
    tbl[6]  = '{1,0,32'h20,0,           0,0,32'h00,0,           0,0,1,32'h20, 0,1,32'hDEADBEEF,     0,0};
    tbl[7]  = '{1,0,32'h30,0,           1,0,32'h44,0,           1,0,1,32'h44, 1,1,0,                0,0};
    tbl[8]  = '{1,0,32'h30,0,           1,0,32'h44,0,           0,0,1,32'h44, 1,1,0,                1,init_word(17)};
    tbl[9]  = '{1,0,32'h30,0,           0,0,32'h00,0,           1,0,1,32'h30, 1,1,0,                0,0};
    tbl[10] = '{1,0,32'h30,0,           0,0,32'h00,0,           0,0,1,32'h30, 0,1,init_word(12),    0,0};
    tbl[11] = '{0,0,32'h00,0,           1,1,32'h48,32'h12345678,1,1,1,32'h48, 0,0,0,                1,0};
    tbl[12] = '{1,0,32'h48,0,           1,0,32'h48,0,           1,0,1,32'h48, 1,1,0,                0,0};
    tbl[13] = '{1,0,32'h48,0,           1,0,32'h48,0,           0,0,1,32'h48, 0,1,32'h12345678,     0,0};
    tbl[14] = '{0,0,32'h00,0,           1,0,32'h48,0,           1,0,1,32'h48, 0,1,0,                0,0};
    tbl[15] = '{0,0,32'h00,0,           1,0,32'h48,0,           0,0,1,32'h48, 0,1,0,                1,32'h12345678};
    tbl[16] = '{0,0,32'h00,0,           0,0,32'h00,0,           0,0,0,32'h00, 0,1,0,                0,0};

    for (int i = 0; i < 17; i++) begin
      set_all(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
              tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
      tick();
      chk($sformatf("t%0d_en", i), s_en[0], tbl[i].e_en);
      chk($sformatf("t%0d_we", i), s_we[0], tbl[i].e_we);
      if (tbl[i].chk_a) chk($sformatf("t%0d_addr", i), s_addr[0], tbl[i].e_addr);
      chk($sformatf("t%0d_stall", i), s_stall[0], tbl[i].e_stall);
      if (tbl[i].chk_rd) begin
        chk($sformatf("t%0d_crd", i), s_crd[0], tbl[i].e_crd);
        chk($sformatf("t%0d_drd", i), s_drd[0], tbl[i].e_drd);
      end
      chk($sformatf("t%0d_ack", i), s_ack[0], tbl[i].e_ack);
    end

    // LAT=3 DMA read 0x40, CPU read 0x80 rising mid-access
    reset = 1'b1; set_all(0, 0, 0, 0, 0, 0, 0, 0); tick(); reset = 1'b0;
    e_en1  = '{1, 0, 0, 0, 1, 0, 0, 0};
    e_ack1 = '{0, 0, 0, 1, 0, 0, 0, 0};
    e_st1  = '{0, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      set_all(i >= 1, 0, 32'h80, 0, i < 4, 0, 32'h40, 0);
      tick();
      chk($sformatf("d%0d_en", i), s_en[1], e_en1[i]);
      chk($sformatf("d%0d_ack", i), s_ack[1], e_ack1[i]);
      chk($sformatf("d%0d_stall", i), s_stall[1], e_st1[i]);
      chk($sformatf("d%0d_addr", i), s_addr[1], (i < 4) ? 32'h40 : 32'h80);
      if (i == 3) chk("d3_drd", s_drd[1], init_word(16));
      if (i == 7) chk("d7_crd", s_crd[1], init_word(32));
    end
    set_all(0, 0, 0, 0, 0, 0, 0, 0); tick();

    // Reset at cnt=1 of a LAT=3 DMA read
    set_all(0, 0, 0, 0, 1, 0, 32'h40, 0);
    tick();
    reset = 1'b1;
    #1;
    snap();
    chk("rmid_state", s_st[1], 2'd0);
    chk("rmid_en", s_en[1], 0);
    chk("rmid_ack", s_ack[1], 0);
    set_all(1, 0, 32'h84, 0, 1, 0, 32'h88, 0);
    tick();
    reset = 1'b0;

    // Saturated reads after reset: strict alternation starting with the CPU
    exp_q = {32'h84, 32'h88, 32'h84, 32'h88};
    first_k1 = -1; acks_k1 = 0; seen_k1 = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (s_en[0] && exp_q.size() > 0) chk($sformatf("fair_c%0d", c), s_addr[0], exp_q.pop_front());
      if (c < 4 && s_ack[1]) acks_k1++;
      if (s_en[1] && !seen_k1) begin
        seen_k1 = 1; first_k1 = c;
        chk("rst_first_addr", s_addr[1], 32'h84);
      end
    end
    chk("fair_left", exp_q.size(), 0);
    chk("rst_first_cycle", first_k1, 0);
    chk("rst_no_ack", acks_k1, 0);

    // Randomized traffic checked by the reference model
    set_all(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (cpu_req_i[k]) begin
          if (m_cpu_done[k]) begin
            if ($urandom_range(1, 0) == 1) cpu_req_i[k] = 0; else new_cpu(k);
          end else if ($urandom_range(99, 0) < 2) cpu_req_i[k] = 0;
        end else if ($urandom_range(99, 0) < 40) new_cpu(k);

        if (dma_req_i[k]) begin
          if (m_dma_done[k]) begin
            if ($urandom_range(1, 0) == 1) dma_req_i[k] = 0; else new_dma(k);
          end else if (!(busy[k] > 0 && owner[k] == 1) && $urandom_range(99, 0) < 3)
            dma_req_i[k] = 0;
        end else if ($urandom_range(99, 0) < 40) new_dma(k);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
